mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline, sitting directly downstream of the EX/MEM pipeline register and consuming every field it outputs. Issues data-memory load/store transactions over a valid/ready request and valid response interface. Stalls the EX/MEM register (and everything upstream) while a transaction is outstanding. Resolves the next PC and registers the write-back fields into the MEM/WB pipeline register.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/mem_wb_pipeline_register.sv | 23 ++
 rtl/mem_stage.sv | 122 ++++++++++++
 tb/tb_mem_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings and types for the CPU pipeline stages.
package cpu_pkg;

   typedef enum logic [1:0] {
      NPC_SEQ  = 2'd0,
      NPC_BRZ  = 2'd1,
      NPC_JAL  = 2'd2,
      NPC_JALR = 2'd3
   } next_pc_src_e;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_RAM  = 2'd1,
      WB_PC4  = 2'd2,
      WB_RSVD = 2'd3
   } reg_write_data_src_e;

   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_RESP = 1'b1
   } mem_state_e;

   localparam logic [31:0] PC_STEP = 32'd4;

   typedef struct packed {
      logic [4:0]  rd_address;
      logic [31:0] data;
      logic        reg_write_enable;
   } wb_t;

endpackage

// File: rtl/mem_wb_pipeline_register.sv
// MEM/WB pipeline register: write-enabled flops with synchronous active-low reset.
module mem_wb_pipeline_register
   import cpu_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic write_enable_i,
   input  wb_t  wb_d_i,
   output wb_t  wb_q_o
);

   wb_t wb_q;

   always_ff @(posedge clk) begin
      if (!reset_n)
         wb_q <= '0;
      else if (write_enable_i)
         wb_q <= wb_d_i;
   end

   assign wb_q_o = wb_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: data-memory handshake FSM, pipeline stall, branch
// resolution and MEM/WB write-back selection.
module mem_stage
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] pc_data,
   input  logic [31:0] rs2_data,
   input  logic [31:0] alu_rd_result,
   input  logic [31:0] alu_pc_result,
   input  logic [4:0]  rd_address,
   input  logic        alu_rd_result_is_zero,
   input  logic        reg_write_enable,
   input  logic        ram_write_enable,
   input  logic [1:0]  next_pc_src,
   input  logic [1:0]  reg_write_data_src,
   output logic        stall,
   output logic        branch_taken,
   output logic [31:0] branch_target,
   output logic        mem_req_valid,
   output logic        mem_req_write,
   output logic [31:0] mem_req_addr,
   output logic [31:0] mem_req_wdata,
   input  logic        mem_req_ready,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_rdata,
   output logic [4:0]  wb_rd_address,
   output logic [31:0] wb_data,
   output logic        wb_reg_write_enable,
   output logic [31:0] stall_cycles
);

   mem_state_e          state_q, state_d;
   logic [31:0]         stall_cycles_q, stall_cycles_d;
   reg_write_data_src_e wsrc;
   next_pc_src_e        npc;
   logic                mem_op, resp_done, take;
   wb_t                 wb_d, wb_q;

   assign wsrc = reg_write_data_src_e'(reg_write_data_src);
   assign npc  = next_pc_src_e'(next_pc_src);

   assign mem_op    = ram_write_enable | (wsrc == WB_RAM);
   assign resp_done = (state_q == WAIT_RESP) & mem_resp_valid;
   assign stall     = mem_op & ~resp_done;

   assign mem_req_valid = (state_q == IDLE) & mem_op;
   assign mem_req_write = ram_write_enable;
   assign mem_req_addr  = {alu_rd_result[31:2], 2'b00};
   assign mem_req_wdata = rs2_data;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (mem_req_valid & mem_req_ready) state_d = WAIT_RESP;
         WAIT_RESP: if (mem_resp_valid) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall && (stall_cycles_q != 32'hFFFF_FFFF))
         stall_cycles_d = stall_cycles_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign stall_cycles = stall_cycles_q;

   // Stall cycles load a bubble so a held instruction writes back only once.
   always_comb begin
      wb_d = '0;
      if (!stall) begin
         wb_d.rd_address       = rd_address;
         wb_d.reg_write_enable = reg_write_enable & (rd_address != 5'd0);
         case (wsrc)
            WB_RAM:  wb_d.data = mem_resp_rdata;
            WB_PC4:  wb_d.data = pc_data + PC_STEP;
            default: wb_d.data = alu_rd_result;
         endcase
      end
   end

   mem_wb_pipeline_register u_mem_wb (
      .clk            (clk),
      .reset_n        (reset_n),
      .write_enable_i (1'b1),
      .wb_d_i         (wb_d),
      .wb_q_o         (wb_q)
   );

   assign wb_rd_address       = wb_q.rd_address;
   assign wb_data             = wb_q.data;
   assign wb_reg_write_enable = wb_q.reg_write_enable;

   always_comb begin
      take          = 1'b0;
      branch_target = alu_pc_result;
      case (npc)
         NPC_BRZ:  take = alu_rd_result_is_zero;
         NPC_JAL:  take = 1'b1;
         NPC_JALR: begin
            take          = 1'b1;
            branch_target = {alu_rd_result[31:1], 1'b0};
         end
         default:  take = 1'b0;
      endcase
   end

   assign branch_taken = take & ~stall;

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized bench for mem_stage with a cycle-level memory model.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] pc_data, rs2_data, alu_rd_result, alu_pc_result;
   logic [4:0]  rd_address;
   logic        alu_rd_result_is_zero, reg_write_enable, ram_write_enable;
   logic [1:0]  next_pc_src, reg_write_data_src;
   logic        stall, branch_taken;
   logic [31:0] branch_target;
   logic        mem_req_valid, mem_req_write;
   logic [31:0] mem_req_addr, mem_req_wdata;
   logic        mem_req_ready, mem_resp_valid;
   logic [31:0] mem_resp_rdata;
   logic [4:0]  wb_rd_address;
   logic [31:0] wb_data;
   logic        wb_reg_write_enable;
   logic [31:0] stall_cycles;

   int checks = 0;
   int errors = 0;
   int stall_exp = 0;

   typedef struct {
      logic [31:0] pc, rs2, alu, alupc;
      logic [4:0]  rd;
      logic        z, rwe, mwe;
      logic [1:0]  npc, wsrc;
   } instr_t;

   mem_stage dut (
      .clk(clk), .reset_n(reset_n),
      .pc_data(pc_data), .rs2_data(rs2_data),
      .alu_rd_result(alu_rd_result), .alu_pc_result(alu_pc_result),
      .rd_address(rd_address), .alu_rd_result_is_zero(alu_rd_result_is_zero),
      .reg_write_enable(reg_write_enable), .ram_write_enable(ram_write_enable),
      .next_pc_src(next_pc_src), .reg_write_data_src(reg_write_data_src),
      .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
      .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
      .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
      .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
      .mem_resp_rdata(mem_resp_rdata),
      .wb_rd_address(wb_rd_address), .wb_data(wb_data),
      .wb_reg_write_enable(wb_reg_write_enable), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic apply(input instr_t i);
      pc_data = i.pc; rs2_data = i.rs2; alu_rd_result = i.alu; alu_pc_result = i.alupc;
      rd_address = i.rd; alu_rd_result_is_zero = i.z; reg_write_enable = i.rwe;
      ram_write_enable = i.mwe; next_pc_src = i.npc; reg_write_data_src = i.wsrc;
   endtask

   function automatic instr_t mk(input logic [31:0] pc, rs2, alu, alupc, input logic [4:0] rd,
                                 input logic z, rwe, mwe, input logic [1:0] npc, wsrc);
      instr_t r;
      r.pc = pc; r.rs2 = rs2; r.alu = alu; r.alupc = alupc; r.rd = rd;
      r.z = z; r.rwe = rwe; r.mwe = mwe; r.npc = npc; r.wsrc = wsrc;
      return r;
   endfunction

   // Runs one instruction to completion; called just after a rising edge.
   task automatic do_instr(input instr_t i, input int rdy_lat, input int rsp_lat,
                           input logic [31:0] rdata);
      logic        memop, etk, ewe;
      logic [31:0] ed, etg;
      memop = i.mwe || (i.wsrc == 2'd1);
      etk   = (i.npc == 2'd1) ? i.z : (i.npc >= 2'd2);
      etg   = (i.npc == 2'd3) ? (i.alu & 32'hFFFF_FFFE) : i.alupc;
      ed    = (i.wsrc == 2'd1) ? rdata : (i.wsrc == 2'd2) ? i.pc + 32'd4 : i.alu;
      ewe   = i.rwe && (i.rd != 5'd0);
      apply(i);
      if (memop) begin
         for (int c = 0; c <= rdy_lat; c++) begin
            mem_req_ready  = (c == rdy_lat);
            mem_resp_valid = (c < rdy_lat);
            mem_resp_rdata = $urandom;
            #4;
            chk("req_valid", mem_req_valid, 1);
            chk("stall_req", stall, 1);
            chk("req_addr", mem_req_addr, {i.alu[31:2], 2'b00});
            chk("req_write", mem_req_write, i.mwe);
            chk("req_wdata", mem_req_wdata, i.rs2);
            chk("br_in_stall", branch_taken, 0);
            @(posedge clk); #1;
            stall_exp++;
            chk("wb_we_stall", wb_reg_write_enable, 0);
         end
         mem_req_ready  = 1'b0;
         mem_resp_valid = 1'b0;
         for (int c = 1; c < rsp_lat; c++) begin
            #4;
            chk("req_valid_wait", mem_req_valid, 0);
            chk("stall_wait", stall, 1);
            @(posedge clk); #1;
            stall_exp++;
            chk("wb_we_wait", wb_reg_write_enable, 0);
         end
         mem_resp_valid = 1'b1;
         mem_resp_rdata = rdata;
      end
      #4;
      chk("stall_done", stall, 0);
      chk("br_taken", branch_taken, etk);
      if (etk) chk("br_target", branch_target, etg);
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = $urandom;
      chk("wb_data", wb_data, ed);
      chk("wb_rd", wb_rd_address, i.rd);
      chk("wb_we", wb_reg_write_enable, ewe);
      chk("stall_cycles", stall_cycles, stall_exp);
   endtask

   initial begin
      instr_t bub, ins;
      bub = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      reset_n = 1'b0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
      apply(bub);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wb_data", wb_data, 0);
      chk("rst_wb_rd", wb_rd_address, 0);
      chk("rst_wb_we", wb_reg_write_enable, 0);
      chk("rst_stall_cycles", stall_cycles, 0);
      #4;
      chk("rst_req_valid", mem_req_valid, 0);
      chk("rst_stall", stall, 0);
      chk("rst_br", branch_taken, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // ALU op, load, store with slow ready
      do_instr(mk(32'h10, 0, 32'h1234, 0, 5, 0, 1, 0, 0, 0), 0, 1, 0);
      do_instr(mk(32'h14, 0, 32'h103, 0, 7, 0, 1, 0, 0, 1), 0, 2, 32'hDEADBEEF);
      chk("load_stall_cycles", stall_cycles, 2);
      do_instr(mk(32'h18, 32'hCAFE_F00D, 32'h200, 0, 0, 0, 0, 1, 0, 0), 3, 2, 32'h5555_5555);

      // branches and JAL wrap
      do_instr(mk(32'h1C, 0, 0, 32'h80, 0, 1, 0, 0, 1, 0), 0, 1, 0);
      do_instr(mk(32'h20, 0, 5, 32'h80, 0, 0, 0, 0, 1, 0), 0, 1, 0);
      do_instr(mk(32'h24, 0, 32'h41, 32'h99, 0, 0, 0, 0, 3, 0), 0, 1, 0);
      do_instr(mk(32'hFFFF_FFFC, 0, 32'h7, 32'h300, 1, 0, 1, 0, 2, 2), 0, 1, 0);
      // write to x0 is suppressed; back-to-back loads
      do_instr(mk(32'h28, 0, 32'h77, 0, 0, 0, 1, 0, 0, 0), 0, 1, 0);
      do_instr(mk(32'h2C, 0, 32'h40, 0, 3, 0, 1, 0, 0, 1), 0, 1, 32'h1111_2222);
      do_instr(mk(32'h30, 0, 32'h44, 0, 4, 0, 1, 0, 0, 1), 1, 1, 32'h3333_4444);

      // reset while waiting for a response
      apply(mk(32'h34, 0, 32'h50, 0, 6, 0, 1, 0, 0, 1));
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      reset_n = 1'b0;
      apply(bub);
      @(posedge clk); #1;
      stall_exp = 0;
      chk("mrst_stall_cycles", stall_cycles, 0);
      chk("mrst_wb_data", wb_data, 0);
      chk("mrst_wb_we", wb_reg_write_enable, 0);
      chk("mrst_wb_rd", wb_rd_address, 0);
      #4;
      chk("mrst_stall", stall, 0);
      chk("mrst_req_valid", mem_req_valid, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      do_instr(mk(32'h38, 0, 32'h60, 0, 9, 0, 1, 0, 0, 1), 0, 1, 32'hABCD_0123);

      // randomized instruction stream
      for (int n = 0; n < 40; n++) begin
         ins = mk($urandom, $urandom, $urandom, $urandom, 5'($urandom),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                  2'($urandom), 2'($urandom));
         do_instr(ins, $urandom_range(0, 3), $urandom_range(1, 3), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
